// File: rtl/bomberman_pkg.sv
// -----------------------------------------------------------------------------
// bomberman_pkg
// Shared definitions for the keyboard front end of the game:
//   - kbd_state_t : decoder FSM states (IDLE, EXT, BRK, EXT_BRK)
//   - PS/2 set-2 prefix and status codes (E0, F0, AA, FC)
//   - scan codes of every mapped key and the bit index of each key output
//   - key_hit()   : does a decoded (code, extended) pair select a given key
// Optional feature macro: KBD_BOMB_KEYS_EN adds the two bomb keys
// (space = 29, right ctrl = E0-14) as key indices 8 and 9.
// -----------------------------------------------------------------------------
package bomberman_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    // Prefix and keyboard status codes
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BRK      = 8'hF0;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;

    // Player 1: W/S/A/D, non-extended
    localparam logic [7:0] SC_P1_UP    = 8'h1D;
    localparam logic [7:0] SC_P1_DOWN  = 8'h1B;
    localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
    localparam logic [7:0] SC_P1_RIGHT = 8'h23;
    // Player 2: arrow keys, E0-extended
    localparam logic [7:0] SC_P2_UP    = 8'h75;
    localparam logic [7:0] SC_P2_DOWN  = 8'h72;
    localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P2_RIGHT = 8'h74;
    // Bomb keys: space (non-extended), right ctrl (extended)
    localparam logic [7:0] SC_P1_BOMB  = 8'h29;
    localparam logic [7:0] SC_P2_BOMB  = 8'h14;

    // Bit positions of the key outputs inside the decoder's key vector
    localparam int KEY_J1_UP    = 0;
    localparam int KEY_J1_DOWN  = 1;
    localparam int KEY_J1_LEFT  = 2;
    localparam int KEY_J1_RIGHT = 3;
    localparam int KEY_J2_UP    = 4;
    localparam int KEY_J2_DOWN  = 5;
    localparam int KEY_J2_LEFT  = 6;
    localparam int KEY_J2_RIGHT = 7;
    localparam int KEY_J1_BOMB  = 8;
    localparam int KEY_J2_BOMB  = 9;

`ifdef KBD_BOMB_KEYS_EN
    localparam int NUM_KEYS = 10;
`else
    localparam int NUM_KEYS = 8;
`endif

    // True when the byte 'code', decoded with extended flag 'ext', belongs
    // to key index 'idx'. A right code with the wrong extended flag is a miss.
    function automatic logic key_hit(input int idx, input logic [7:0] code, input logic ext);
        logic hit;
        hit = 1'b0;
        case (idx)
            KEY_J1_UP:    hit = !ext && (code == SC_P1_UP);
            KEY_J1_DOWN:  hit = !ext && (code == SC_P1_DOWN);
            KEY_J1_LEFT:  hit = !ext && (code == SC_P1_LEFT);
            KEY_J1_RIGHT: hit = !ext && (code == SC_P1_RIGHT);
            KEY_J2_UP:    hit =  ext && (code == SC_P2_UP);
            KEY_J2_DOWN:  hit =  ext && (code == SC_P2_DOWN);
            KEY_J2_LEFT:  hit =  ext && (code == SC_P2_LEFT);
            KEY_J2_RIGHT: hit =  ext && (code == SC_P2_RIGHT);
            KEY_J1_BOMB:  hit = !ext && (code == SC_P1_BOMB);
            KEY_J2_BOMB:  hit =  ext && (code == SC_P2_BOMB);
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/keyboard_decoder.sv
// -----------------------------------------------------------------------------
// keyboard_decoder
// Turns the PS/2 set-2 scan-code byte stream into held-key levels for two
// players. E0/F0 prefixes are tracked by a 4-state FSM; a prefix left hanging
// for TIMEOUT_CYCLES clocks is abandoned. AA/FC from the keyboard (self-test
// after reconnect) releases every key.
//
// Parameters:
//   TIMEOUT_CYCLES  prefix-abandon timeout in clk cycles
// Ports:
//   clk                     system clock, posedge
//   reset_n                 asynchronous active-low reset
//   scan_code[7:0]          byte from the PS/2 receiver
//   scan_valid              one-cycle strobe qualifying scan_code
//   j1_up/down/left/right   player-1 held keys (registered)
//   j2_up/down/left/right   player-2 held keys (registered)
//   j1_bomb, j2_bomb        bomb keys, only when KBD_BOMB_KEYS_EN is defined
// Optional feature macro: KBD_BOMB_KEYS_EN
// -----------------------------------------------------------------------------
module keyboard_decoder
    import bomberman_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic       j1_up,
    output logic       j1_down,
    output logic       j1_left,
    output logic       j1_right,
    output logic       j2_up,
    output logic       j2_down,
    output logic       j2_left,
`ifdef KBD_BOMB_KEYS_EN
    output logic       j2_right,
    output logic       j1_bomb,
    output logic       j2_bomb
`else
    output logic       j2_right
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    kbd_state_t          state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [NUM_KEYS-1:0] keys_reg, keys_next;

    logic ev_valid;     // a non-prefix byte completed a make/break sequence
    logic ev_ext;       // that sequence started with E0
    logic ev_brk;       // that sequence contained F0
    logic clear_all;    // keyboard self-test code seen in IDLE
    logic timeout_hit;

    // Timeout fires only in a cycle without a byte; a byte arriving in the
    // same cycle is decoded normally.
    assign timeout_hit = (state_reg != ST_IDLE) && (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        ev_valid   = 1'b0;
        ev_ext     = 1'b0;
        ev_brk     = 1'b0;
        clear_all  = 1'b0;
        if (scan_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (scan_code == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (scan_code == SC_BRK) begin
                        state_next = ST_BRK;
                    end else begin
                        ev_valid  = 1'b1;
                        clear_all = (scan_code == SC_BAT_OK) || (scan_code == SC_BAT_FAIL);
                    end
                end
                ST_EXT: begin
                    if (scan_code == SC_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if (scan_code != SC_EXT) begin
                        ev_valid   = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (scan_code == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (scan_code != SC_BRK) begin
                        ev_valid   = 1'b1;
                        ev_brk     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin // ST_EXT_BRK
                    if (scan_code == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (scan_code != SC_BRK) begin
                        ev_valid   = 1'b1;
                        ev_ext     = 1'b1;
                        ev_brk     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            endcase
        end else if (timeout_hit) begin
            state_next = ST_IDLE;
        end
    end

    // Counter idles at zero in IDLE, restarts on every byte, and parks at the
    // timeout value instead of wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (scan_valid || (state_reg == ST_IDLE)) begin
            cnt_next = '0;
        end else if (!timeout_hit) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic hit;
            assign hit = ev_valid && key_hit(gi, scan_code, ev_ext);
            // Make sets, break clears; a repeated make simply keeps the 1.
            assign keys_next[gi] = clear_all ? 1'b0 :
                                   hit       ? !ev_brk :
                                               keys_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            keys_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            keys_reg  <= keys_next;
        end
    end

    assign j1_up    = keys_reg[KEY_J1_UP];
    assign j1_down  = keys_reg[KEY_J1_DOWN];
    assign j1_left  = keys_reg[KEY_J1_LEFT];
    assign j1_right = keys_reg[KEY_J1_RIGHT];
    assign j2_up    = keys_reg[KEY_J2_UP];
    assign j2_down  = keys_reg[KEY_J2_DOWN];
    assign j2_left  = keys_reg[KEY_J2_LEFT];
    assign j2_right = keys_reg[KEY_J2_RIGHT];
`ifdef KBD_BOMB_KEYS_EN
    assign j1_bomb  = keys_reg[KEY_J1_BOMB];
    assign j2_bomb  = keys_reg[KEY_J2_BOMB];
`endif

endmodule

// File: tb/tb_keyboard_decoder.sv
// -----------------------------------------------------------------------------
// tb_keyboard_decoder
// Directed bench for keyboard_decoder with TIMEOUT_CYCLES = 16. Each byte sent
// pushes the expected key vector {j2_right,j2_left,j2_down,j2_up,
// j1_right,j1_left,j1_down,j1_up} onto a scoreboard queue; after the clock
// edge that consumes the byte the vector is popped and compared.
// -----------------------------------------------------------------------------
module tb_keyboard_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       j1_up, j1_down, j1_left, j1_right;
    logic       j2_up, j2_down, j2_left, j2_right;
`ifdef KBD_BOMB_KEYS_EN
    logic       j1_bomb, j2_bomb;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    keyboard_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .j1_up     (j1_up),
        .j1_down   (j1_down),
        .j1_left   (j1_left),
        .j1_right  (j1_right),
        .j2_up     (j2_up),
        .j2_down   (j2_down),
        .j2_left   (j2_left),
`ifdef KBD_BOMB_KEYS_EN
        .j2_right  (j2_right),
        .j1_bomb   (j1_bomb),
        .j2_bomb   (j2_bomb)
`else
        .j2_right  (j2_right)
`endif
    );

    function automatic logic [7:0] keys();
        return {j2_right, j2_left, j2_down, j2_up, j1_right, j1_left, j1_down, j1_up};
    endfunction

    task automatic check_now(input string tag, input logic [7:0] expected);
        logic [7:0] observed;
        observed = keys();
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: keys observed %02h expected %02h", tag, observed, expected);
        end
        $display("check %-14s keys=%02h expected=%02h", tag, observed, expected);
    endtask

    // Called at a falling edge: present the byte for one cycle, then compare
    // the outputs one cycle later against the value queued with the byte.
    task automatic send(input string tag, input logic [7:0] code, input logic [7:0] expected);
        logic [7:0] want;
        exp_q.push_back(expected);
        scan_code  = code;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed %02h expected queued value", tag, keys());
        end else begin
            want = exp_q.pop_front();
            check_now(tag, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_now("reset", 8'h00);
        reset_n = 1'b1;
        idle(2);

        // Make / break of P1 up
        send("p1up_make",  8'h1D, 8'h01);
        send("f0_prefix",  8'hF0, 8'h01);
        send("p1up_break", 8'h1D, 8'h00);

        // Extended P2 up, then a lone 75 (wrong extended flag)
        send("e0_prefix",  8'hE0, 8'h00);
        send("p2up_make",  8'h75, 8'h10);
        send("lone_75",    8'h75, 8'h10);

        // P2 left make then extended break
        send("e0_prefix2", 8'hE0, 8'h10);
        send("p2left_mk",  8'h6B, 8'h50);
        send("e0_prefix3", 8'hE0, 8'h50);
        send("f0_prefix2", 8'hF0, 8'h50);
        send("p2left_brk", 8'h6B, 8'h10);

        // Unmapped codes in the default build (bomb keys absent)
        send("unmapped29", 8'h29, 8'h10);
        send("e0_prefix4", 8'hE0, 8'h10);
        send("unmapped14", 8'h14, 8'h10);

        // Typematic repeat keeps the key held
        send("p1up_make2", 8'h1D, 8'h11);
        send("p1up_rept",  8'h1D, 8'h11);

        // Byte arriving in the very cycle the timeout would fire still wins
        send("f0_race",    8'hF0, 8'h11);
        idle(15);
        send("race_break", 8'h1D, 8'h10);

        // Prefix abandoned after the timeout: 23 decodes as a make
        send("f0_timeout", 8'hF0, 8'h10);
        idle(16);
        send("to_make23",  8'h23, 8'h18);

        // Self-test pass clears everything
        send("p1left_mk",  8'h1C, 8'h1C);
        send("p1down_mk",  8'h1B, 8'h1E);
        send("e0_prefix5", 8'hE0, 8'h1E);
        send("p2right_mk", 8'h74, 8'h9E);
        send("bat_aa",     8'hAA, 8'h00);

        // Self-test fail clears as well
        send("p1up_make3", 8'h1D, 8'h01);
        send("bat_fc",     8'hFC, 8'h00);

        // Reset in the middle of an E0 sequence
        send("e0_prefix6", 8'hE0, 8'h00);
        send("p2up_make2", 8'h75, 8'h10);
        send("e0_prefix7", 8'hE0, 8'h10);
        #2 reset_n = 1'b0;
        #1 check_now("async_reset", 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        send("post_rst_72", 8'h72, 8'h00);
        send("e0_prefix8",  8'hE0, 8'h00);
        send("p2down_mk",   8'h72, 8'h20);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keyboard_decoder.md
KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2_000_000 (20 ms at 100 MHz), prefix-abandon timeout in clk cycles.
REQ-002 clk  input  1  system clock; all logic on posedge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 scan_code  input  8  PS/2 scan-code byte from the upstream serial receiver.
REQ-005 scan_valid  input  1  one-cycle strobe; scan_code is valid in that cycle.
REQ-006 j1_up, j1_down, j1_left, j1_right  output  1 each  player-1 held-key levels, to the position controller.
REQ-007 j2_up, j2_down, j2_left, j2_right  output  1 each  player-2 held-key levels, to the position controller.
REQ-008 j1_bomb, j2_bomb  output  1 each  bomb-key held levels; present only with KBD_BOMB_KEYS_EN.

Function
REQ-009 Key map SHALL be: P1 W=1D up, S=1B down, A=1C left, D=23 right; P2 E0-75 up, E0-72 down, E0-6B left, E0-74 right.
REQ-010 Decoding SHALL use a 4-state FSM: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-011 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make event (non-extended), stay IDLE.
REQ-012 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> extended make event, -> IDLE.
REQ-013 BRK: other byte -> non-extended break event, -> IDLE; E0 -> EXT; F0 -> stay BRK.
REQ-014 EXT_BRK: other byte -> extended break event, -> IDLE; E0 -> EXT; F0 -> stay EXT_BRK.
REQ-015 Make event on a mapped code SHALL set the matching output; break event SHALL clear it.
REQ-016 Unmapped codes, or a mapped code with the wrong extended flag (e.g. 75 without E0), SHALL change no output and SHALL still return the FSM to IDLE.
REQ-017 Outputs SHALL be registered; latency 1 cycle from the scan_valid cycle carrying the final byte.
REQ-018 Repeated make codes (typematic) SHALL leave an already-set output at 1.
REQ-019 Opposing directions of the same player MAY both be 1; no arbitration here.
REQ-020 A counter SHALL run while the FSM is not IDLE; cleared on every scan_valid.
REQ-021 When the counter reaches TIMEOUT_CYCLES-1 with no scan_valid, the FSM SHALL return to IDLE next cycle; outputs unchanged.
REQ-022 scan_valid in the cycle the timeout fires SHALL win: the byte is processed, no timeout.
REQ-023 Counter width SHALL be $clog2(TIMEOUT_CYCLES); it SHALL not wrap (saturates at timeout).
REQ-024 Code 0xAA (self-test pass) or 0xFC (fail) in IDLE SHALL clear all key outputs (keyboard reconnected).

Reset
REQ-025 reset_n low SHALL force FSM to IDLE, counter to 0, every key output to 0, immediately.
REQ-026 Reset mid-sequence (after E0/F0) SHALL discard the prefix; the next byte is decoded from IDLE.

Configuration
REQ-027 With KBD_BOMB_KEYS_EN defined: ports j1_bomb (space, 29) and j2_bomb (right ctrl, E0-14) exist and follow REQ-015..018/024.
REQ-028 Without KBD_BOMB_KEYS_EN: those ports and their flops are absent; 29 and E0-14 are unmapped per REQ-016.

Structure
REQ-029 Shared package bomberman_pkg SHALL hold the FSM state enum typedef and all scan-code constants (E0, F0, AA, FC, mapped keys).
REQ-030 No sub-module inside; the PS/2 serial receiver ps2_rx is the natural separate upstream module and is instantiated alongside, not within.

Verification
REQ-031 Bytes 1D then F0 1D -> j1_up 1 one cycle after 1D, 0 one cycle after the second 1D.
REQ-032 E0 75, then 75 alone -> j2_up=1 after E0 75; lone 75 changes nothing, j1_* all 0.
REQ-033 E0 F0 6B with j2_left=1 -> j2_left=0; all other outputs unchanged.
REQ-034 TIMEOUT_CYCLES=16: F0, idle 16 cycles, then 23 -> FSM back in IDLE, j1_right=1 (make, not break).
REQ-035 Hold 1C, 1B, E0 74, then AA -> all outputs 0 one cycle after AA.
REQ-036 Assert reset_n low right after E0, release, send 72 -> all outputs 0, j2_down stays 0 (72 decoded non-extended).
